// File: rtl/rv32i_pkg.sv
// Shared fetch-side definitions: state encoding, instruction size, reset pc and target helper.
// FETCH_MISALIGN_EN keeps target[1:0] intact so fetch_ctrl can trap misaligned targets.
package rv32i_pkg;

  typedef enum logic [2:0] {
    StReq,
    StWait,
    StOut,
    StKill,
    StHalt
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] redirect_target(input logic is_jalr, input logic [31:0] alu_res);
    logic [31:0] t;
    t = is_jalr ? {alu_res[31:1], 1'b0} : alu_res;
`ifndef FETCH_MISALIGN_EN
    t[1:0] = 2'b00;
`endif
    return t;
  endfunction

endpackage

// File: rtl/redirect_latch.sv
// Holds a redirect that could not be applied yet because a request is still in flight.
// set wins over clear so a redirect coinciding with the release is never lost.
module redirect_latch (
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  logic [31:0] target,
  input  logic        clear,
  output logic        pend,
  output logic [31:0] pend_addr
);

  logic        pend_q;
  logic [31:0] pend_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pend_addr_q <= 32'h0000_0000;
    end else if (set) begin
      pend_q      <= 1'b1;
      pend_addr_q <= target;
    end else if (clear) begin
      pend_q      <= 1'b0;
    end
  end

  assign pend      = pend_q;
  assign pend_addr = pend_addr_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the pc, issues one imem request at a time, drops stale data.
// Define FETCH_MISALIGN_EN to halt on a misaligned redirect target instead of aligning it.
module fetch_ctrl
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_out,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] alu_out,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fetch_misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  if_pc_q, if_instr_q;
  logic         req_q;
  logic         capture;
  logic         redirect;
  logic [31:0]  target;
  logic         gnt_eff;
  logic         pend, pend_set, pend_clr;
  logic [31:0]  pend_addr;

  assign redirect = branch_out | jal | jalr;
  assign target   = redirect_target(jalr, alu_out);
  // A grant only counts while the request line is actually up (not in the post-reset cycle).
  assign gnt_eff  = imem_gnt & req_q;

  redirect_latch u_redirect_latch (
    .clk       (clk),
    .rst       (rst),
    .set       (pend_set),
    .target    (target),
    .clear     (pend_clr),
    .pend      (pend),
    .pend_addr (pend_addr)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      StReq: begin
        if (gnt_eff) begin
          state_d  = (redirect || pend) ? StKill : StWait;
          pend_set = redirect;
        end else begin
          pend_set = redirect;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          if (redirect) begin
            state_d = StReq;
            pc_d    = target;
          end else begin
            state_d = StOut;
            capture = 1'b1;
          end
        end else if (redirect) begin
          state_d  = StKill;
          pend_set = 1'b1;
        end
      end
      StKill: begin
        if (imem_rvalid) begin
          state_d  = StReq;
          pc_d     = redirect ? target : pend_addr;
          pend_clr = 1'b1;
        end else begin
          pend_set = redirect;
        end
      end
      StOut: begin
        if (redirect) begin
          state_d = StReq;
          pc_d    = target;
        end else if (!stall) begin
          state_d = StReq;
          pc_d    = pc_q + 32'(INSTR_BYTES);
        end
      end
`ifdef FETCH_MISALIGN_EN
      StHalt: begin
        state_d = StHalt;
      end
`endif
      default: begin
        state_d = StReq;
      end
    endcase
`ifdef FETCH_MISALIGN_EN
    if (redirect && (target[1:0] != 2'b00) && (state_q != StHalt)) begin
      state_d  = StHalt;
      pend_set = 1'b0;
      pend_clr = 1'b0;
      capture  = 1'b0;
    end
`endif
  end

`ifdef FETCH_MISALIGN_EN
  logic misalign_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_instr_q <= 32'h0000_0000;
`ifdef FETCH_MISALIGN_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= (state_d == StReq);
      if (capture) begin
        if_instr_q <= imem_rdata;
        if_pc_q    <= pc_q;
      end
`ifdef FETCH_MISALIGN_EN
      if (state_d == StHalt) misalign_q <= 1'b1;
`endif
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign if_valid  = (state_q == StOut);
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;

`ifdef FETCH_MISALIGN_EN
  assign fetch_misalign = misalign_q;
`else
  assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed stimulus pushes expected requests and outputs,
// monitors pop and compare; a small memory model answers with word = addr ^ 0x13.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_out = 1'b0, jal = 1'b0, jalr = 1'b0, stall = 1'b0;
  logic [31:0] alu_out = 32'h0;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req, if_valid, fetch_misalign;
  logic [31:0] imem_addr, if_pc, if_instr;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .branch_out     (branch_out),
    .jal            (jal),
    .jalr           (jalr),
    .alu_out        (alu_out),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .fetch_misalign (fetch_misalign)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model knobs
  int gnt_delay = 0;
  int rv_delay = 1;
  int grants = 0;
  int req_wait = 0;
  int rv_cnt = -1;
  logic [31:0] rv_addr = 32'h0;

  logic [31:0] exp_req[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp_instr[$];
  int          pop_cyc[$];

  logic        hold_prev = 1'b0;
  logic [31:0] held_pc = 32'h0, held_instr = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_slot();
    @(negedge clk);
    #1;
  endtask

  task automatic push_req(input logic [31:0] a);
    exp_req.push_back(a);
  endtask

  task automatic push_out(input logic [31:0] pc, input logic [31:0] instr);
    exp_pc.push_back(pc);
    exp_instr.push_back(instr);
  endtask

  task automatic wait_gnt(input string name);
    for (int i = 0; i < 40; i++) begin
      sample_slot();
      if (imem_req && imem_gnt) return;
    end
    flag(name);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 40; i++) begin
      sample_slot();
      if (if_valid) return;
    end
    flag(name);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100; i++) begin
      sample_slot();
      if (exp_req.size() == 0 && exp_pc.size() == 0) return;
    end
    flag(name);
    exp_req.delete();
    exp_pc.delete();
    exp_instr.delete();
  endtask

  // Memory: grants after gnt_delay requesting cycles while budget lasts, rvalid rv_delay later.
  always @(negedge clk) begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    if (rst) begin
      rv_cnt   = -1;
      req_wait = 0;
    end else begin
      if (rv_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = rv_addr ^ 32'h0000_0013;
        rv_cnt      = -1;
      end else if (rv_cnt > 0) begin
        rv_cnt--;
      end
      if (imem_req && grants > 0) begin
        if (req_wait >= gnt_delay) begin
          imem_gnt = 1'b1;
          grants--;
          req_wait = 0;
          rv_addr  = imem_addr;
          rv_cnt   = rv_delay - 1;
        end else begin
          req_wait++;
        end
      end
    end
  end

  // Request monitor
  always begin
    @(negedge clk);
    #1;
    if (!rst && imem_req && imem_gnt) begin
      if (exp_req.size() == 0) flag($sformatf("unexpected_req addr=%h", imem_addr));
      else check("req_addr", imem_addr, exp_req.pop_front());
    end
  end

  // Output monitor: one pop per presentation; held presentations must not change.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (if_valid && !hold_prev) begin
        if (exp_pc.size() == 0) begin
          flag($sformatf("unexpected_if_valid pc=%h", if_pc));
        end else begin
          check("if_pc", if_pc, exp_pc.pop_front());
          check("if_instr", if_instr, exp_instr.pop_front());
        end
        pop_cyc.push_back(cyc);
        held_pc    = if_pc;
        held_instr = if_instr;
      end else if (if_valid && hold_prev) begin
        check("held_if_pc", if_pc, held_pc);
        check("held_if_instr", if_instr, held_instr);
      end
      hold_prev = if_valid && stall && !(branch_out || jal || jalr);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    sample_slot();
    check("rst_imem_req", 32'(imem_req), 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_misalign", 32'(fetch_misalign), 32'h0);

    // zero-wait sequential fetch, 3-cycle spacing
    drive_slot();
    rst = 1'b0;
    grants = 3;
    pop_cyc.delete();
    push_req(32'h0); push_req(32'h4); push_req(32'h8);
    push_out(32'h0, 32'h13); push_out(32'h4, 32'h17); push_out(32'h8, 32'h1b);
    wait_drain("seq_drain");
    if (pop_cyc.size() == 3) begin
      check("spacing_0_1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd3);
      check("spacing_1_2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd3);
    end else begin
      flag("spacing_count");
    end

    // stall holds OUT for 5 cycles with no request
    drive_slot();
    stall = 1'b1;
    grants = 1;
    push_req(32'hC);
    push_out(32'hC, 32'h1f);
    wait_valid("stall_valid");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) sample_slot();
      check("stall_if_valid", 32'(if_valid), 32'h1);
      check("stall_no_req", 32'(imem_req), 32'h0);
      check("stall_if_pc", if_pc, 32'hC);
    end
    drive_slot();
    stall = 1'b0;
    grants = 1;
    push_req(32'h10);
    push_out(32'h10, 32'h03);
    wait_drain("stall_drain");

    // jal during WAIT: response dropped, refetch at 0x100
    drive_slot();
    rv_delay = 3;
    grants = 2;
    push_req(32'h14); push_req(32'h100);
    push_out(32'h100, 32'h113);
    wait_gnt("jal_gnt");
    drive_slot();
    jal = 1'b1;
    alu_out = 32'h100;
    rv_delay = 1;
    drive_slot();
    jal = 1'b0;
    sample_slot();
    check("kill_no_req", 32'(imem_req), 32'h0);
    wait_drain("jal_drain");

    // redirect in REQ while gnt is held low for 3 cycles
    drive_slot();
    branch_out = 1'b1;
    alu_out = 32'h200;
    gnt_delay = 3;
    grants = 2;
    push_req(32'h104); push_req(32'h200);
    push_out(32'h200, 32'h213);
    drive_slot();
    branch_out = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) sample_slot();
      else sample_slot();
      check("pend_addr_stable", imem_addr, 32'h104);
      check("pend_req_up", 32'(imem_req), 32'h1);
    end
    wait_drain("pend_drain");
    drive_slot();
    gnt_delay = 0;

    // jalr in OUT (under stall) with odd target -> 0x300
    grants = 1;
    stall = 1'b1;
    push_req(32'h204);
    push_out(32'h204, 32'h217);
    wait_valid("jalr_valid");
    drive_slot();
    jalr = 1'b1;
    alu_out = 32'h301;
    drive_slot();
    jalr = 1'b0;
    stall = 1'b0;
    grants = 1;
    push_req(32'h300);
    push_out(32'h300, 32'h313);
    wait_drain("jalr_drain");

    // jal together with gnt, then pc wrap 0xFFFFFFFC -> 0
    drive_slot();
    jal = 1'b1;
    alu_out = 32'hFFFF_FFFC;
    grants = 3;
    push_req(32'h304); push_req(32'hFFFF_FFFC); push_req(32'h0);
    push_out(32'hFFFF_FFFC, 32'hFFFF_FFEF); push_out(32'h0, 32'h13);
    drive_slot();
    jal = 1'b0;
    wait_drain("wrap_drain");

    // reset in WAIT aborts the fetch
    drive_slot();
    rv_delay = 3;
    grants = 1;
    push_req(32'h4);
    wait_gnt("rst_gnt");
    drive_slot();
    rst = 1'b1;
    drive_slot();
    rst = 1'b0;
    rv_delay = 1;
    grants = 1;
    push_req(32'h0);
    push_out(32'h0, 32'h13);
    sample_slot();
    check("midrst_imem_addr", imem_addr, 32'h0);
    check("midrst_if_valid", 32'(if_valid), 32'h0);
    check("midrst_imem_req", 32'(imem_req), 32'h0);
    sample_slot();
    check("postrst_imem_req", 32'(imem_req), 32'h1);
    check("postrst_imem_addr", imem_addr, 32'h0);
    wait_drain("midrst_drain");

    // misaligned branch target
    drive_slot();
    branch_out = 1'b1;
    alu_out = 32'h302;
`ifdef FETCH_MISALIGN_EN
    drive_slot();
    branch_out = 1'b0;
    grants = 1;
    for (int i = 0; i < 3; i++) begin
      sample_slot();
      check("halt_misalign", 32'(fetch_misalign), 32'h1);
      check("halt_no_req", 32'(imem_req), 32'h0);
      check("halt_no_valid", 32'(if_valid), 32'h0);
    end
    drive_slot();
    rst = 1'b1;
    grants = 0;
    drive_slot();
    rst = 1'b0;
    sample_slot();
    check("halt_cleared", 32'(fetch_misalign), 32'h0);
`else
    grants = 2;
    push_req(32'h4); push_req(32'h300);
    push_out(32'h300, 32'h313);
    drive_slot();
    branch_out = 1'b0;
    wait_drain("align_drain");
    check("no_misalign", 32'(fetch_misalign), 32'h0);
`endif

    repeat (3) sample_slot();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
